mem_seq: RTL and testbench
==========================

# mem_seq

Memory-stage access sequencer for the byte-wide data SRAM. It takes one decoded `mem_op` plus the effective address and store data, and splits the access into 1, 2 or 4 single-byte SRAM cycles. It stalls the pipeline until the access completes, then returns a sign- or zero-extended 32-bit load result. It sits between the execute-stage ALU result and the external 8-bit SRAM.

## Interface
- `ADDR_W`, 16: SRAM byte-address width.
- `WAIT_CYCLES`, 1: cycles each byte strobe is held active. Range 1..7.

- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: memory-stage instruction is valid.
- `mem_op`  in  10: bit 9 sign, 8 byte, 7 half, 6 word, 5 load, 4 store, 3:0 unshifted byte enables (0001/0011/1111).
- `addr`  in  32: effective byte address.
- `wdata`  in  32: store data, right-aligned.
- `stall`  out  1: hold the upstream pipeline.
- `rdata`  out  32: extended load result.
- `rdata_valid`  out  1: one-cycle completion pulse, for loads and stores.
- `misaligned`  out  1: rejected request.
- `ram_addr`  out  ADDR_W: SRAM address.
- `ram_dout`  out  8: SRAM write data.
- `ram_din`  in  8: SRAM read data.
- `ram_ce_n`, `ram_oe_n`, `ram_we_n`  out  1 each: active-low SRAM strobes.

## Operation
- **Lane mask:** `lanes = (mem_op[3:0] << addr[1:0])`, truncated to 4 bits.
- **Misaligned:** half with `addr[0]=1`, or word with `addr[1:0]!=0`.
- **States:**
  - IDLE, ACCESS, GAP, DONE.
- **IDLE:**
  - A request is accepted when `req_valid` is high and exactly one of load or store is set.
  - Accepted and aligned: latch op, address, store data and lanes; current lane = lowest set lane; → ACCESS.
  - Accepted but misaligned: `misaligned=1` combinationally; no SRAM access; `stall=0`; stay in IDLE.
  - Load and store both set, or neither set: ignored.
- **ACCESS:**
  - Hold for WAIT_CYCLES cycles.
  - `ram_addr = {addr[ADDR_W-1:2], lane}`, `ce_n=0`.
  - Load: `oe_n=0`; on the last wait cycle, capture `ram_din` into byte `lane` of the read buffer.
  - Store: `we_n=0`; `ram_dout = wdata` byte `(lane - addr[1:0])`.
- **GAP:** one cycle with all strobes high (write recovery / bus turnaround). Then the next set lane → ACCESS, otherwise → DONE.
- **DONE:** one cycle; `rdata_valid=1`; → IDLE.
  - Load `rdata` = buffer shifted right by `8*addr[1:0]`, then extended from bit 7 (byte) or bit 15 (half) using the sign bit; word is unmodified.
  - Store leaves `rdata` unchanged.
- **Stall:** `stall = (IDLE & accepted & aligned) | ACCESS | GAP`. It is 0 in DONE, so the pipeline advances on the DONE cycle.
- Request inputs are held stable by the stall; they are latched in IDLE and not re-read.

## Timing
- `ram_*` outputs, `rdata` and `rdata_valid` are registered. `stall` and `misaligned` are combinational.
- **Reset values:** IDLE; strobes 1; `ram_addr` 0; `ram_dout` 0; `rdata` 0; `rdata_valid` 0. `stall` and `misaligned` are forced to 0 while `rst` is high.
- **Latency:** request in cycle 0; DONE in cycle `1 + n*(WAIT_CYCLES+1)`, where n = number of lanes.
  - With `WAIT_CYCLES=1`: byte → DONE at cycle 3; half at 5; word at 9.
- **Reset mid-access:** at the next edge, strobes go high, state is IDLE, no `rdata_valid`. A partial store may have reached the SRAM.
- **Back-to-back:** a new request is sampled in the IDLE cycle right after DONE; there is no dead cycle beyond that.

## Structure
- Package `mem_pkg`:
  - `mem_op` bit indices (SIGN, BYTE, HALF, WORD, LOAD, STORE, BE).
  - State encoding.
  - Misalignment predicate.
- Sub-module `mem_ext`: combinational shift plus sign/zero extension from `{buffer, addr[1:0], byte, half, sign}` to 32 bits.
- Lane walk: priority encoder over the remaining lanes, with each lane cleared after its GAP cycle.

## Test plan
- **lb, sign extension:** `addr=0x0003`, `mem_op` lb, SRAM[3]=0x80 → one ACCESS at `ram_addr=3`; DONE at cycle 3; `rdata=0xFFFFFF80`.
- **lhu:** `addr=0x0102`, SRAM[0x102]=0x34, SRAM[0x103]=0xA5 → two accesses (0x102 then 0x103); `rdata=0x0000A534`; stall high for cycles 0–4.
- **sw:** `addr=0x0010`, `wdata=0xDEADBEEF` → writes 0xEF, 0xBE, 0xAD, 0xDE to 0x10–0x13; `we_n` low only in ACCESS; `rdata_valid` at cycle 9.
- **Misaligned:** lw at `addr=0x0005` → `misaligned=1` in the same cycle; no strobe activity; `stall=0`.
- **Reset mid-access:** `rst` during the second ACCESS of a word load → strobes high next cycle; no `rdata_valid`; a new lb is accepted after reset is released.
- **`WAIT_CYCLES=3`:** byte load → strobe held 3 cycles; DONE at cycle 5.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-stage byte sequencer.
//   - bit positions inside the decoded mem_op word
//   - sequencer state encoding
//   - alignment predicate and lane priority helper
package mem_pkg;

    localparam int OP_W     = 10;
    localparam int OP_SIGN  = 9;
    localparam int OP_BYTE  = 8;
    localparam int OP_HALF  = 7;
    localparam int OP_WORD  = 6;
    localparam int OP_LOAD  = 5;
    localparam int OP_STORE = 4;
    localparam int OP_BE_HI = 3;
    localparam int OP_BE_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_GAP    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // A halfword must sit on an even address, a word on a multiple of four.
    function automatic logic is_misaligned(input logic [OP_W-1:0] op, input logic [1:0] off);
        return (op[OP_HALF] && off[0]) || (op[OP_WORD] && (off != 2'b00));
    endfunction

    // Index of the lowest set lane; 0 when no lane is set.
    function automatic logic [1:0] lowest_lane(input logic [3:0] lanes);
        logic [1:0] idx;
        idx = 2'd0;
        if (lanes[0])      idx = 2'd0;
        else if (lanes[1]) idx = 2'd1;
        else if (lanes[2]) idx = 2'd2;
        else if (lanes[3]) idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/mem_seq_if.sv
// mem_seq_if: bundle between the pipeline / SRAM side and the sequencer.
//   Request : req_valid, mem_op[9:0], addr[31:0], wdata[31:0]
//   Response: stall, rdata[31:0], rdata_valid, misaligned
//   SRAM    : ram_addr[ADDR_W-1:0], ram_dout[7:0], ram_din[7:0],
//             ram_ce_n, ram_oe_n, ram_we_n (active low)
// master = pipeline and SRAM side, slave = the sequencer.
interface mem_seq_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic [9:0]        mem_op;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              stall;
    logic [31:0]       rdata;
    logic              rdata_valid;
    logic              misaligned;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;
    logic              ram_ce_n;
    logic              ram_oe_n;
    logic              ram_we_n;

    modport master (
        output req_valid, mem_op, addr, wdata, ram_din,
        input  stall, rdata, rdata_valid, misaligned,
               ram_addr, ram_dout, ram_ce_n, ram_oe_n, ram_we_n
    );

    modport slave (
        input  req_valid, mem_op, addr, wdata, ram_din,
        output stall, rdata, rdata_valid, misaligned,
               ram_addr, ram_dout, ram_ce_n, ram_oe_n, ram_we_n
    );
endinterface

// File: rtl/mem_ext.sv
// mem_ext: aligns the assembled read buffer to bit 0 and extends it.
//   i_buf[31:0] : bytes as they sit in the addressed word
//   i_off[1:0]  : byte offset of the access inside the word
//   i_byte      : byte access, extend from bit 7
//   i_half      : halfword access, extend from bit 15
//   i_sign      : sign-extend when set, zero-extend otherwise
//   o_data[31:0]: load result (word accesses pass through)
module mem_ext (
    input  logic [31:0] i_buf,
    input  logic [1:0]  i_off,
    input  logic        i_byte,
    input  logic        i_half,
    input  logic        i_sign,
    output logic [31:0] o_data
);
    logic [31:0] w_shifted;

    assign w_shifted = i_buf >> {i_off, 3'b000};

    always_comb begin
        o_data = w_shifted;
        if (i_byte) begin
            o_data = {{24{i_sign & w_shifted[7]}}, w_shifted[7:0]};
        end else if (i_half) begin
            o_data = {{16{i_sign & w_shifted[15]}}, w_shifted[15:0]};
        end
    end
endmodule

// File: rtl/mem_seq.sv
// mem_seq: splits a byte/half/word load or store into single-byte SRAM
// cycles (ACCESS held WAIT_CYCLES, then one GAP cycle per byte), stalls the
// pipeline meanwhile and pulses rdata_valid for one DONE cycle at the end.
//   clk, rst : clock and synchronous active-high reset
//   bus      : mem_seq_if slave (request, response and SRAM signals)
// SRAM strobes, ram_addr/ram_dout, rdata and rdata_valid are registered;
// stall and misaligned are combinational.
module mem_seq
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic     clk,
    input  logic     rst,
    mem_seq_if.slave bus
);
    state_t            r_state, w_state_next;
    logic [OP_W-1:0]   w_op;
    logic              w_is_load, w_is_store;
    logic              w_accept, w_bad_align, w_start;
    logic [3:0]        w_lanes_in, w_lanes_left, r_lanes;
    logic [1:0]        r_lane, w_lane_next;
    logic [1:0]        r_off, w_off_src, w_byte_sel;
    logic [ADDR_W-3:0] r_addr_hi, w_hi_src;
    logic [31:0]       r_wdata, w_wdata_src, r_buf, w_ext;
    logic              r_load, r_sign, r_byte, r_half, w_load_src;
    logic [2:0]        r_wait;
    logic              w_last_wait;
    logic              r_ce_n, r_oe_n, r_we_n, r_rdata_valid;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [7:0]        r_ram_dout, w_dout_next;
    logic [31:0]       r_rdata;
    logic              w_unused_addr;

    assign w_op        = bus.mem_op;
    assign w_is_load   = w_op[OP_LOAD];
    assign w_is_store  = w_op[OP_STORE];
    assign w_accept    = (r_state == ST_IDLE) && bus.req_valid && (w_is_load ^ w_is_store);
    assign w_bad_align = is_misaligned(w_op, bus.addr[1:0]);
    assign w_start     = w_accept && !w_bad_align;
    // Byte enables moved to the addressed lanes; bits above lane 3 drop off.
    assign w_lanes_in  = w_op[OP_BE_HI:OP_BE_LO] << bus.addr[1:0];
    assign w_lanes_left = r_lanes & ~(4'b0001 << r_lane);
    assign w_last_wait = (r_wait == 3'(WAIT_CYCLES - 1));
    assign w_unused_addr = ^bus.addr[31:ADDR_W];

    // The first SRAM cycle is launched from IDLE, before the request is
    // latched, so its address/data come straight from the request inputs.
    assign w_off_src   = (r_state == ST_IDLE) ? bus.addr[1:0]          : r_off;
    assign w_hi_src    = (r_state == ST_IDLE) ? bus.addr[ADDR_W-1:2]   : r_addr_hi;
    assign w_wdata_src = (r_state == ST_IDLE) ? bus.wdata              : r_wdata;
    assign w_load_src  = (r_state == ST_IDLE) ? w_is_load              : r_load;
    // Store data is right-aligned, so SRAM lane L takes data byte L - offset.
    assign w_byte_sel  = w_lane_next - w_off_src;
    assign w_dout_next = w_wdata_src[{w_byte_sel, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_lane_next  = r_lane;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = ST_ACCESS;
                    w_lane_next  = lowest_lane(w_lanes_in);
                end
            end
            ST_ACCESS: begin
                if (w_last_wait) begin
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_lanes_left != 4'b0000) begin
                    w_state_next = ST_ACCESS;
                    w_lane_next  = lowest_lane(w_lanes_left);
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane        <= 2'd0;
            r_lanes       <= 4'b0000;
            r_off         <= 2'd0;
            r_addr_hi     <= '0;
            r_wdata       <= '0;
            r_buf         <= '0;
            r_load        <= 1'b0;
            r_sign        <= 1'b0;
            r_byte        <= 1'b0;
            r_half        <= 1'b0;
            r_wait        <= 3'd0;
            r_ce_n        <= 1'b1;
            r_oe_n        <= 1'b1;
            r_we_n        <= 1'b1;
            r_ram_addr    <= '0;
            r_ram_dout    <= 8'h00;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_lane        <= w_lane_next;
            // Strobes follow the state being entered so they are registered
            // yet line up exactly with the ACCESS cycles.
            r_ce_n        <= !(w_state_next == ST_ACCESS);
            r_oe_n        <= !((w_state_next == ST_ACCESS) && w_load_src);
            r_we_n        <= !((w_state_next == ST_ACCESS) && !w_load_src);
            r_rdata_valid <= (w_state_next == ST_DONE);

            if (w_state_next == ST_ACCESS) begin
                r_ram_addr <= {w_hi_src, w_lane_next};
                if (!w_load_src) begin
                    r_ram_dout <= w_dout_next;
                end
            end

            if ((w_state_next == ST_DONE) && r_load) begin
                r_rdata <= w_ext;
            end

            if (w_start) begin
                r_lanes   <= w_lanes_in;
                r_off     <= bus.addr[1:0];
                r_addr_hi <= bus.addr[ADDR_W-1:2];
                r_wdata   <= bus.wdata;
                r_buf     <= '0;
                r_load    <= w_is_load;
                r_sign    <= w_op[OP_SIGN];
                r_byte    <= w_op[OP_BYTE];
                r_half    <= w_op[OP_HALF];
                r_wait    <= 3'd0;
            end

            if (r_state == ST_ACCESS) begin
                if (w_last_wait) begin
                    r_wait <= 3'd0;
                    if (r_load) begin
                        r_buf[{r_lane, 3'b000} +: 8] <= bus.ram_din;
                    end
                end else begin
                    r_wait <= r_wait + 3'd1;
                end
            end

            // Retire the lane just accessed so the encoder moves on.
            if (r_state == ST_GAP) begin
                r_lanes <= w_lanes_left;
            end
        end
    end

    mem_ext u_ext (
        .i_buf  (r_buf),
        .i_off  (r_off),
        .i_byte (r_byte),
        .i_half (r_half),
        .i_sign (r_sign),
        .o_data (w_ext)
    );

    assign bus.stall       = !rst && (w_start || (r_state == ST_ACCESS) || (r_state == ST_GAP));
    assign bus.misaligned  = !rst && w_accept && w_bad_align;
    assign bus.rdata       = r_rdata;
    assign bus.rdata_valid = r_rdata_valid;
    assign bus.ram_addr    = r_ram_addr;
    assign bus.ram_dout    = r_ram_dout;
    assign bus.ram_ce_n    = r_ce_n;
    assign bus.ram_oe_n    = r_oe_n;
    assign bus.ram_we_n    = r_we_n;
endmodule

// File: tb/tb_mem_seq.sv
`timescale 1ns/1ps
module tb_mem_seq;
    import mem_pkg::*;

    localparam int ADDR_W = 16;
    localparam int W      = 1;

    typedef struct {
        logic [31:0] rdata;
        int          done_cyc;
        int          strobes;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   strobe_cnt = 0;
    logic [31:0] last_rdata = '0;
    exp_t sb_q[$];
    logic [7:0] sram    [0:65535];
    logic [7:0] ref_mem [0:65535];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_seq_if #(.ADDR_W(ADDR_W)) bus ();
    mem_seq_if #(.ADDR_W(ADDR_W)) bus3 ();

    mem_seq #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    mem_seq #(.ADDR_W(ADDR_W), .WAIT_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    assign bus.ram_din  = sram[bus.ram_addr];
    assign bus3.ram_din = 8'hC3;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) ^ (i >> 3));
    endfunction

    // SRAM model: contents start from init_byte, writes land mid-cycle.
    initial begin
        for (int i = 0; i < 65536; i++) sram[i] = init_byte(i);
        forever begin
            @(negedge clk);
            if (!bus.ram_ce_n && !bus.ram_we_n) sram[bus.ram_addr] = bus.ram_dout;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] make_op(input int sz, input bit ld, input bit sg);
        logic [9:0] op;
        op = '0;
        op[OP_SIGN]  = sg;
        op[OP_LOAD]  = ld;
        op[OP_STORE] = !ld;
        if (sz == 0) begin op[OP_BYTE] = 1'b1; op[3:0] = 4'b0001; end
        else if (sz == 1) begin op[OP_HALF] = 1'b1; op[3:0] = 4'b0011; end
        else begin op[OP_WORD] = 1'b1; op[3:0] = 4'b1111; end
        return op;
    endfunction

    // Monitor: pops the scoreboard on every completion pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!bus.ram_ce_n) strobe_cnt++;
            if (!bus.ram_we_n) check("we_strobe_combo", 32'({bus.ram_ce_n, bus.ram_oe_n}), 32'h1);
            if (bus.rdata_valid) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_valid: rdata_valid=1 at cycle %0d, expected 0", cyc);
                end else begin
                    e = sb_q.pop_front();
                    $display("[TB] done cyc=%0d rdata=0x%h strobes=%0d", cyc, bus.rdata, strobe_cnt);
                    check("rdata", bus.rdata, e.rdata);
                    check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    check("strobe_cycles", 32'(strobe_cnt), 32'(e.strobes));
                end
                strobe_cnt = 0;
            end
        end
    end

    // Issue one request; caller is at #1 after a rising edge.
    task automatic do_req(input int sz, input bit ld, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd);
        bit mis;
        int nb;
        int k;
        exp_t e;
        logic [31:0] v;
        nb  = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        mis = (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
        bus.req_valid = 1'b1;
        bus.mem_op    = make_op(sz, ld, sg);
        bus.addr      = a;
        bus.wdata     = wd;
        if (!mis) begin
            if (ld) begin
                v = '0;
                for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[16'(a[15:0] + 16'(i))]) << (8 * i));
                if (sg && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
                last_rdata = v;
            end else begin
                for (int i = 0; i < nb; i++) ref_mem[16'(a[15:0] + 16'(i))] = 8'(wd >> (8 * i));
            end
            e.rdata    = last_rdata;
            e.done_cyc = cyc + 1 + nb * (W + 1);
            e.strobes  = nb * W;
            sb_q.push_back(e);
        end
        @(negedge clk);
        check("misaligned_c0", 32'(bus.misaligned), 32'(mis));
        check("stall_c0", 32'(bus.stall), 32'(!mis));
        if (!mis) begin
            k = 0;
            while (bus.stall && k < 100) begin
                @(negedge clk);
                k++;
            end
            if (bus.stall) begin
                n_tests++;
                n_fail++;
                $display("FAIL stall_timeout: stall=1 after %0d cycles, expected 0", k);
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Load and store both set, or neither: must be ignored.
    task automatic do_bad(input bit both);
        logic [9:0] op;
        op = make_op(0, 1'b1, 1'b0);
        op[OP_LOAD]  = both;
        op[OP_STORE] = both;
        bus.req_valid = 1'b1;
        bus.mem_op    = op;
        bus.addr      = 32'h0000_0101;
        @(negedge clk);
        check("ignored_stall", 32'(bus.stall), 32'h0);
        check("ignored_misaligned", 32'(bus.misaligned), 32'h0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int sz;
        int cnt3;
        int done3;
        logic [31:0] rd3;
        logic [31:0] a;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
        bus.mem_op     = make_op(2, 1'b1, 1'b0);
        bus.addr       = 32'h0000_0005;
        bus.wdata      = '0;
        bus.req_valid  = 1'b1;
        bus3.req_valid = 1'b0;
        bus3.mem_op    = '0;
        bus3.addr      = '0;
        bus3.wdata     = '0;

        // Reset values, with a misaligned request pending during reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_strobes", 32'({bus.ram_ce_n, bus.ram_oe_n, bus.ram_we_n}), 32'h7);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_rdata_valid", 32'(bus.rdata_valid), 32'h0);
        check("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
        check("rst_ram_dout", 32'(bus.ram_dout), 32'h0);
        check("rst_stall", 32'(bus.stall), 32'h0);
        check("rst_misaligned", 32'(bus.misaligned), 32'h0);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed cases.
        do_req(0, 1'b0, 1'b0, 32'h0000_0003, 32'h0000_0080);   // sb 0x80 -> [3]
        do_req(0, 1'b1, 1'b1, 32'h0000_0003, 32'h0);           // lb -> FFFFFF80
        do_req(1, 1'b0, 1'b0, 32'h0000_0102, 32'h0000_A534);   // sh
        do_req(1, 1'b1, 1'b0, 32'h0000_0102, 32'h0);           // lhu -> 0000A534
        do_req(2, 1'b0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);   // sw
        do_req(2, 1'b1, 1'b0, 32'h0000_0010, 32'h0);           // lw readback
        do_req(2, 1'b1, 1'b0, 32'h0000_0005, 32'h0);           // misaligned lw
        do_req(1, 1'b1, 1'b1, 32'h0000_0013, 32'h0);           // misaligned lh
        do_bad(1'b1);
        do_bad(1'b0);

        // Randomised traffic around a small window so loads hit stored data.
        for (int t = 0; t < 250; t++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_bad(1'($urandom_range(0, 1)));
            end else begin
                sz = $urandom_range(0, 2);
                a  = 32'h0000_0100 + 32'($urandom_range(0, 31));
                if ($urandom_range(0, 3) != 0) begin
                    if (sz == 1) a[0] = 1'b0;
                    if (sz == 2) a[1:0] = 2'b00;
                end
                if ($urandom_range(0, 3) == 0) a[31:16] = 16'($urandom);
                do_req(sz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
            end
        end

        // Reset during the second ACCESS of a word load.
        bus.req_valid = 1'b1;
        bus.mem_op    = make_op(2, 1'b1, 1'b0);
        bus.addr      = 32'h0000_0104;
        repeat (1 + (W + 1)) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_stall", 32'(bus.stall), 32'h0);
        check("midrst_ce_before_edge", 32'(bus.ram_ce_n), 32'h0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("midrst_strobes", 32'({bus.ram_ce_n, bus.ram_oe_n, bus.ram_we_n}), 32'h7);
        check("midrst_rdata_valid", 32'(bus.rdata_valid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        strobe_cnt = 0;
        last_rdata = '0;
        repeat (4) @(posedge clk);
        #1;
        do_req(0, 1'b1, 1'b1, 32'h0000_0003, 32'h0);

        // Byte load on the WAIT_CYCLES=3 instance.
        bus3.req_valid = 1'b1;
        bus3.mem_op    = make_op(0, 1'b1, 1'b0);
        bus3.addr      = 32'h0000_0020;
        cnt3  = 0;
        done3 = -1;
        rd3   = '0;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (!bus3.ram_ce_n) cnt3++;
            if (bus3.rdata_valid && done3 < 0) begin
                done3 = c;
                rd3   = bus3.rdata;
            end
            if (!bus3.stall) bus3.req_valid = 1'b0;
        end
        $display("[TB] wait3 lbu done=%0d strobes=%0d rdata=0x%h", done3, cnt3, rd3);
        check("wait3_strobes", 32'(cnt3), 32'd3);
        check("wait3_done_cycle", 32'(done3), 32'd5);
        check("wait3_rdata", rd3, 32'h0000_00C3);

        repeat (5) @(posedge clk);
        check("scoreboard_drain", 32'(sb_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
